i2s_master_port: RTL and testbench

I2S_MASTER_PORT -- requirements
Module: i2s_master_port

---
 rtl/i2s_master_port.sv | 134 +++++++++++++
 tb/tb_i2s_master_port.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_master_port.sv
// rtl/i2s_master_port.sv - I2S (Philips) bus master: bclk/lrc generation, serialiser and capture
module i2s_master_port #(
    parameter int WL  = 24,
    parameter int DIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          aud_bclk,
    output logic          aud_lrc,
    output logic          aud_adcdat,
    input  logic          aud_dacdat,
    input  logic [WL-1:0] tx_left,
    input  logic [WL-1:0] tx_right,
    output logic          tx_ready,
    output logic [WL-1:0] rx_left,
    output logic [WL-1:0] rx_right,
    output logic          rx_valid
);

    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [5:0]    WL6      = 6'(WL);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_cnt;
    logic [5:0]    bit_cnt;
    logic [WL-1:0] hold_l, hold_r;
    logic [WL-1:0] cap_l, cap_r;

    logic          entry, leave, tick, fall, rise;
    logic [5:0]    nb;
    logic [WL-1:0] tx_sel, tx_mask, rx_mask;
    logic          tx_bit;

    // One-hot mask for slot position p: bit WL-p for p=1..WL, empty otherwise.
    function automatic logic [WL-1:0] slot_mask(input logic [4:0] p);
        logic [5:0] pos;
        pos       = {1'b0, p};
        slot_mask = '0;
        if (pos != 6'd0 && pos <= WL6)
            slot_mask = WL'(32'd1 << (WL6 - pos));
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign entry   = (state_q == IDLE) && en;
    assign leave   = (state_q == RUN) && !en;
    assign tick    = (state_q == RUN) && en && (div_cnt == DIV_LAST);
    assign fall    = tick && aud_bclk;
    assign rise    = tick && !aud_bclk;
    assign nb      = bit_cnt + 6'd1;
    assign tx_sel  = nb[5] ? hold_r : hold_l;
    assign tx_mask = slot_mask(nb[4:0]);
    assign tx_bit  = |(tx_sel & tx_mask);
    assign rx_mask = slot_mask(bit_cnt[4:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            aud_bclk   <= 1'b0;
            aud_lrc    <= 1'b0;
            aud_adcdat <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            cap_l      <= '0;
            cap_r      <= '0;
            rx_left    <= '0;
            rx_right   <= '0;
            tx_ready   <= 1'b0;
            rx_valid   <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            if (entry || leave) begin
                // Both transitions restart from a clean bus; entry additionally latches samples.
                div_cnt    <= '0;
                bit_cnt    <= '0;
                aud_bclk   <= 1'b0;
                aud_lrc    <= 1'b0;
                aud_adcdat <= 1'b0;
                cap_l      <= '0;
                cap_r      <= '0;
                if (entry) begin
                    hold_l   <= tx_left;
                    hold_r   <= tx_right;
                    tx_ready <= 1'b1;
                end
            end else if (state_q == RUN) begin
                if (tick) begin
                    div_cnt  <= '0;
                    aud_bclk <= ~aud_bclk;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                if (fall) begin
                    bit_cnt    <= nb;
                    aud_lrc    <= nb[5];
                    aud_adcdat <= tx_bit;
                    if (nb == 6'd0) begin
                        hold_l   <= tx_left;
                        hold_r   <= tx_right;
                        tx_ready <= 1'b1;
                        rx_left  <= cap_l;
                        rx_right <= cap_r;
                        rx_valid <= 1'b1;
                    end
                end
                if (rise) begin
                    if (bit_cnt[5])
                        cap_r <= aud_dacdat ? (cap_r | rx_mask) : (cap_r & ~rx_mask);
                    else
                        cap_l <= aud_dacdat ? (cap_l | rx_mask) : (cap_l & ~rx_mask);
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_master_port.sv
// tb/tb_i2s_master_port.sv - self-checking loopback bench for i2s_master_port
module tb_i2s_master_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        aud_bclk, aud_lrc, aud_adcdat, aud_dacdat;
    logic [23:0] tx_left, tx_right, rx_left, rx_right;
    logic        tx_ready, rx_valid;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] left_slots;

    assign aud_dacdat = aud_adcdat;

    always #5 clk = ~clk;

    i2s_master_port #(.WL(24), .DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .aud_bclk   (aud_bclk),
        .aud_lrc    (aud_lrc),
        .aud_adcdat (aud_adcdat),
        .aud_dacdat (aud_dacdat),
        .tx_left    (tx_left),
        .tx_right   (tx_right),
        .tx_ready   (tx_ready),
        .rx_left    (rx_left),
        .rx_right   (rx_right),
        .rx_valid   (rx_valid)
    );

    typedef struct {
        logic [23:0] tx_l;
        logic [23:0] tx_r;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
    } vec_t;

    typedef struct {
        int   slot;
        logic bit_v;
    } slot_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Entered at the negedge right after a latch edge; walks one 512-clk frame
    // against an independent waveform model, swaps tx inputs mid-frame, then checks the report.
    task automatic run_frame(input logic [23:0] cl, input logic [23:0] cr,
                             input logic [23:0] nl, input logic [23:0] nr);
        int          e_bclk  = 0;
        int          e_lrc   = 0;
        int          e_adc   = 0;
        int          e_pulse = 0;
        int          bc, p;
        logic [23:0] smp;
        logic        exp_adc;
        logic [31:0] ls = '0;
        for (int c = 0; c < 512; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 40) begin
                tx_left  = nl;
                tx_right = nr;
            end
            bc      = (c >> 3) & 63;
            p       = bc & 31;
            smp     = (bc >= 32) ? cr : cl;
            exp_adc = (p >= 1 && p <= 24) ? smp[24 - p] : 1'b0;
            if (aud_bclk !== 1'((c >> 2) & 1)) e_bclk++;
            if (aud_lrc !== 1'(bc >> 5)) e_lrc++;
            if (aud_adcdat !== exp_adc) e_adc++;
            if (c > 0 && (tx_ready !== 1'b0 || rx_valid !== 1'b0)) e_pulse++;
            if ((c & 7) == 4 && bc < 32) ls[bc] = aud_adcdat;
        end
        @(negedge clk);
        check("bclk_wave_errs", 32'(e_bclk), 32'd0);
        check("lrc_wave_errs", 32'(e_lrc), 32'd0);
        check("adcdat_errs", 32'(e_adc), 32'd0);
        check("early_pulse_errs", 32'(e_pulse), 32'd0);
        check("rx_valid_at_512", 32'(rx_valid), 32'd1);
        check("tx_ready_at_512", 32'(tx_ready), 32'd1);
        check("rx_left", 32'(rx_left), 32'(cl));
        check("rx_right", 32'(rx_right), 32'(cr));
        left_slots = ls;
    endtask

    vec_t  tbl[5];
    slot_t slots[7];

    initial begin
        int idle_errs;

        tbl[0] = '{24'h800001, 24'h7FFFFE, 24'hA5F00F, 24'h123456};
        tbl[1] = '{24'h000000, 24'hFFFFFF, 24'h800001, 24'h7FFFFE};
        tbl[2] = '{24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF};
        tbl[3] = '{24'h5A5A5A, 24'hC3C3C3, 24'hFFFFFF, 24'h000000};
        tbl[4] = '{24'h000001, 24'h800000, 24'h5A5A5A, 24'hC3C3C3};
        slots[0] = '{0, 1'b0};
        slots[1] = '{1, 1'b1};
        slots[2] = '{2, 1'b0};
        slots[3] = '{23, 1'b0};
        slots[4] = '{24, 1'b1};
        slots[5] = '{25, 1'b0};
        slots[6] = '{31, 1'b0};

        rst_n    = 1'b0;
        en       = 1'b0;
        tx_left  = 24'hA5F00F;
        tx_right = 24'h123456;
        repeat (3) @(negedge clk);
        check("rst_bclk", 32'(aud_bclk), 32'd0);
        check("rst_lrc", 32'(aud_lrc), 32'd0);
        check("rst_adcdat", 32'(aud_adcdat), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_left", 32'(rx_left), 32'd0);
        check("rst_rx_right", 32'(rx_right), 32'd0);

        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_bclk", 32'(aud_bclk), 32'd0);
        check("idle_tx_ready", 32'(tx_ready), 32'd0);

        en = 1'b1;
        @(negedge clk);
        check("entry_tx_ready", 32'(tx_ready), 32'd1);
        check("entry_rx_valid", 32'(rx_valid), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].exp_l, tbl[i].exp_r, tbl[i].tx_l, tbl[i].tx_r);
            if (tbl[i].exp_l == 24'h800001) begin
                foreach (slots[k])
                    check($sformatf("slot_%0d", slots[k].slot),
                          32'(left_slots[slots[k].slot]), 32'(slots[k].bit_v));
            end
        end

        // Drop en in the right half at bit_cnt=40, then restart.
        for (int c = 1; c <= 321; c++) @(negedge clk);
        check("pre_drop_lrc", 32'(aud_lrc), 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("drop_bclk", 32'(aud_bclk), 32'd0);
        check("drop_lrc", 32'(aud_lrc), 32'd0);
        check("drop_adcdat", 32'(aud_adcdat), 32'd0);
        idle_errs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rx_valid !== 1'b0 || tx_ready !== 1'b0 || aud_bclk !== 1'b0) idle_errs++;
        end
        check("drop_idle_errs", 32'(idle_errs), 32'd0);
        check("drop_rx_left_hold", 32'(rx_left), 32'h5A5A5A);
        check("drop_rx_right_hold", 32'(rx_right), 32'hC3C3C3);
        en = 1'b1;
        @(negedge clk);
        check("restart_tx_ready", 32'(tx_ready), 32'd1);
        check("restart_lrc", 32'(aud_lrc), 32'd0);
        run_frame(24'h000001, 24'h800000, 24'h000001, 24'h800000);

        // Asynchronous reset mid-frame, between clock edges.
        for (int c = 1; c <= 100; c++) @(negedge clk);
        check("pre_rst_bclk", 32'(aud_bclk), 32'd1);
        #1;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("arst_bclk", 32'(aud_bclk), 32'd0);
        check("arst_lrc", 32'(aud_lrc), 32'd0);
        check("arst_adcdat", 32'(aud_adcdat), 32'd0);
        check("arst_rx_left", 32'(rx_left), 32'd0);
        check("arst_rx_right", 32'(rx_right), 32'd0);
        check("arst_tx_ready", 32'(tx_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_errs = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rx_valid !== 1'b0 || tx_ready !== 1'b0 || aud_bclk !== 1'b0) idle_errs++;
        end
        check("post_rst_idle_errs", 32'(idle_errs), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
